// File: rtl/seg_pkg.sv
// Shared constants for the calculator front-panel 7-segment driver:
// segment codes (active-low {a..g,dp}), converter states and BCD sizing.
package seg_pkg;

    localparam logic [15:0][7:0] SEG_CODE = {
        8'h71, 8'h61, 8'h85, 8'hE5, 8'hC1, 8'h11, 8'h19, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h61;

    typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;

    // Number of decimal digits needed to hold 2^val_w - 1.
    function automatic int bcd_digits(input int val_w);
        longint unsigned v;
        int n;
        v = (64'd1 << val_w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, VAL_W steps.
// bcd carries the final value combinationally during the done cycle.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VAL_W = 16,
    parameter int BCD_W = 4 * bcd_digits(VAL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CNT_W = $clog2(VAL_W);

    conv_state_t      state;
    conv_state_t      state_next;
    logic [VAL_W-1:0] sr;
    logic [BCD_W-1:0] work;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;

    assign busy   = (state == CONV_RUN);
    assign last   = (cnt == CNT_W'(VAL_W - 1));
    assign done   = busy && last;
    assign accept = start && (!busy || last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CONV_IDLE;
        else      state <= state_next;
    end

    // A start accepted on the final step chains straight into a new run.
    always_comb begin
        state_next = state;
        case (state)
            CONV_IDLE: if (accept) state_next = CONV_RUN;
            CONV_RUN:  if (last && !accept) state_next = CONV_IDLE;
            default:   state_next = CONV_IDLE;
        endcase
    end

    always_comb begin
        adj = work;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (work[4*d +: 4] >= 4'd5) adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
        end
        bcd = {adj[BCD_W-2:0], sr[VAL_W-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr   <= '0;
            work <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sr   <= bin;
            work <= '0;
            cnt  <= '0;
        end else if (busy) begin
            sr   <= sr << 1;
            work <= bcd;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_display_gen.sv
// Multiplexed 7-segment driver: keypad entry in the upper digits, converted
// (or raw hex) result in the lower digits, with overflow and zero blanking.
module seg_scan_display_gen
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int ENTRY_DIGITS = 4,
    parameter int VAL_W        = 16,
    parameter int SCAN_DIV     = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_num,
    input  logic              clear,
    input  logic [VAL_W-1:0]  value,
    input  logic              value_valid,
    input  logic              hex_mode,
    input  logic              blank_lz,
    output logic              conv_busy,
    output logic [DIGITS-1:0] led_en,
    output logic [7:0]        led_cx
);

    localparam int RES_DIGITS = DIGITS - ENTRY_DIGITS;
    localparam int RES_W      = 4 * RES_DIGITS;
    localparam int ENT_W      = 4 * ENTRY_DIGITS;
    localparam int BCD_W      = 4 * bcd_digits(VAL_W);
    localparam int DIV_W      = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]       div_cnt;
    logic [ENT_W-1:0]       entry;
    logic [RES_W-1:0]       result;
    logic                   ovf;
    logic [VAL_W-1:0]       pend_val;
    logic                   pend_valid;
    logic                   new_dec;
    logic                   conv_start;
    logic                   conv_done;
    logic [VAL_W-1:0]       conv_bin;
    logic [BCD_W-1:0]       conv_bcd;
    logic [VAL_W+RES_W-1:0] value_ext;
    logic [BCD_W+RES_W-1:0] bcd_ext;
    logic [3:0]             nib;
    int                     slot_idx;
    int                     ent_hi;
    int                     res_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            led_en  <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            led_en  <= {led_en[0], led_en[DIGITS-1:1]};
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           entry <= '0;
        else if (clear)     entry <= '0;
        else if (key_valid) entry <= (entry << 4) | ENT_W'(key_num);
    end

    // A fresh decimal value always beats an older pending one.
    assign new_dec    = value_valid && !hex_mode;
    assign conv_start = (!conv_busy || conv_done) && (new_dec || pend_valid);
    assign conv_bin   = new_dec ? value : pend_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_val   <= '0;
            pend_valid <= 1'b0;
        end else if (conv_start) begin
            pend_valid <= 1'b0;
        end else if (new_dec) begin
            pend_val   <= value;
            pend_valid <= 1'b1;
        end
    end

    bin2bcd_seq #(.VAL_W(VAL_W), .BCD_W(BCD_W)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign value_ext = {{RES_W{1'b0}}, value};
    assign bcd_ext   = {{RES_W{1'b0}}, conv_bcd};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            ovf    <= 1'b0;
        end else if (value_valid && hex_mode) begin
            result <= value_ext[RES_W-1:0];
            ovf    <= |(value_ext >> RES_W);
        end else if (conv_done) begin
            result <= bcd_ext[RES_W-1:0];
            ovf    <= |(bcd_ext >> RES_W);
        end
    end

    always_comb begin
        ent_hi = 0;
        res_hi = 0;
        for (int i = 0; i < ENTRY_DIGITS; i++) if (entry[4*i +: 4] != 4'd0) ent_hi = i;
        for (int i = 0; i < RES_DIGITS; i++)   if (result[4*i +: 4] != 4'd0) res_hi = i;
    end

    // Anything other than exactly one active enable shows blank.
    always_comb begin
        led_cx   = SEG_BLANK;
        nib      = 4'd0;
        slot_idx = 0;
        for (int i = 0; i < DIGITS; i++) if (!led_en[i]) slot_idx = i;
        if ($countones(~led_en) == 1) begin
            if (slot_idx >= RES_DIGITS) begin
                for (int i = 0; i < ENTRY_DIGITS; i++)
                    if (i == slot_idx - RES_DIGITS) nib = entry[4*i +: 4];
                if (!(blank_lz && (slot_idx - RES_DIGITS) > ent_hi)) led_cx = SEG_CODE[nib];
            end else if (ovf) begin
                if (slot_idx == 0) led_cx = SEG_E;
            end else begin
                for (int i = 0; i < RES_DIGITS; i++)
                    if (i == slot_idx) nib = result[4*i +: 4];
                if (!(blank_lz && slot_idx > res_hi)) led_cx = SEG_CODE[nib];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display_gen.sv
// Bench for seg_scan_display_gen: table of result vectors plus hand-written
// scan, entry, pending-chain and reset sequences, checked through a slot scoreboard.
module tb_seg_scan_display_gen;

    localparam int DIGITS   = 8;
    localparam int ENTRY_D  = 4;
    localparam int VAL_W    = 16;
    localparam int SCAN_DIV = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_valid;
    logic [3:0]        key_num;
    logic              clear;
    logic [VAL_W-1:0]  value;
    logic              value_valid;
    logic              hex_mode;
    logic              blank_lz;
    logic              conv_busy;
    logic [DIGITS-1:0] led_en;
    logic [7:0]        led_cx;

    seg_scan_display_gen #(
        .DIGITS(DIGITS), .ENTRY_DIGITS(ENTRY_D), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_num(key_num), .clear(clear),
        .value(value), .value_valid(value_valid), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .conv_busy(conv_busy), .led_en(led_en), .led_cx(led_cx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         slot;
        logic [7:0] seg;
        int         tag;
    } exp_t;

    typedef struct {
        logic [15:0] val;
        logic        hex;
        logic        blz;
        logic [31:0] segs;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   errors = 0;
    int   checks = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_field(input int tag, input int base, input logic [31:0] segs);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            e.slot = base + s;
            e.seg  = segs[8*s +: 8];
            e.tag  = tag;
            sb.push_back(e);
        end
    endtask

    // Each sample pops whichever expectation belongs to the slot currently lit.
    task automatic drain(input int limit);
        int active;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            active = -1;
            for (int i = 0; i < DIGITS; i++) if (led_en == ~(8'b1 << i)) active = i;
            for (int k = 0; k < sb.size(); k++) begin
                if (sb[k].slot == active) begin
                    check_output($sformatf("t%0d slot%0d", sb[k].tag, sb[k].slot),
                                 {24'd0, led_cx}, {24'd0, sb[k].seg});
                    sb.delete(k);
                    break;
                end
            end
        end
        foreach (sb[k]) begin
            checks++;
            errors++;
            $display("[TB] FAIL t%0d slot%0d never scanned: got none expected %h", sb[k].tag, sb[k].slot, sb[k].seg);
        end
        sb.delete();
    endtask

    task automatic apply_stimulus(input logic [15:0] val, input logic hex, input logic blz);
        @(negedge clk);
        hex_mode    = hex;
        blank_lz    = blz;
        value       = val;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] k, input logic clr);
        @(negedge clk);
        key_valid = 1'b1;
        key_num   = k;
        clear     = clr;
        @(negedge clk);
        key_valid = 1'b0;
        clear     = 1'b0;
    endtask

    initial begin
        int blen;
        tbl[0]  = '{16'd1234,  1'b0, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
        tbl[1]  = '{16'd65535, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h61}};
        tbl[2]  = '{16'hBEEF,  1'b1, 1'b0, {8'hC1, 8'h61, 8'h61, 8'h71}};
        tbl[3]  = '{16'd5,     1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h49}};
        tbl[4]  = '{16'd0,     1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
        tbl[5]  = '{16'd9999,  1'b0, 1'b0, {8'h19, 8'h19, 8'h19, 8'h19}};
        tbl[6]  = '{16'd10000, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h61}};
        tbl[7]  = '{16'h00A0,  1'b1, 1'b1, {8'hFF, 8'hFF, 8'h11, 8'h03}};
        tbl[8]  = '{16'h1234,  1'b1, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
        tbl[9]  = '{16'd305,   1'b0, 1'b1, {8'hFF, 8'h0D, 8'h03, 8'h49}};
        tbl[10] = '{16'd700,   1'b0, 1'b0, {8'h03, 8'h1F, 8'h03, 8'h03}};
        tbl[11] = '{16'h0F00,  1'b1, 1'b1, {8'hFF, 8'h71, 8'h03, 8'h03}};

        rst = 1'b0; key_valid = 1'b0; key_num = 4'd0; clear = 1'b0;
        value = '0; value_valid = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;

        repeat (3) @(negedge clk);
        check_output("rst led_en", {24'd0, led_en}, 32'hFE);
        check_output("rst led_cx", {24'd0, led_cx}, 32'h03);
        check_output("rst busy", {31'd0, conv_busy}, 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check_output("scan hold", {24'd0, led_en}, 32'hFE);
        @(negedge clk);
        check_output("scan step1", {24'd0, led_en}, 32'h7F);
        repeat (SCAN_DIV) @(negedge clk);
        check_output("scan step2", {24'd0, led_en}, 32'hBF);

        for (int k = 1; k <= 5; k++) press_key(4'(k), 1'b0);
        push_field(100, 4, {8'h25, 8'h0D, 8'h99, 8'h49});
        push_field(100, 0, {8'h03, 8'h03, 8'h03, 8'h03});
        drain(20);
        press_key(4'd6, 1'b1);
        push_field(101, 4, {8'h03, 8'h03, 8'h03, 8'h03});
        drain(20);
        press_key(4'hA, 1'b0);
        blank_lz = 1'b1;
        push_field(102, 4, {8'hFF, 8'hFF, 8'hFF, 8'h11});
        drain(20);

        for (int t = 0; t < 12; t++) begin
            apply_stimulus(tbl[t].val, tbl[t].hex, tbl[t].blz);
            if (!tbl[t].hex) begin
                blen = 0;
                while (conv_busy && blen < 40) begin
                    blen++;
                    @(negedge clk);
                end
                check_output($sformatf("t%0d busy len", t), blen, 32'd16);
            end else begin
                check_output($sformatf("t%0d hex busy", t), {31'd0, conv_busy}, 32'd0);
            end
            push_field(t, 0, tbl[t].segs);
            drain(20);
        end

        apply_stimulus(16'd1234, 1'b0, 1'b0);
        push_field(200, 0, {8'h03, 8'h71, 8'h03, 8'h03});
        drain(15);
        check_output("old shown busy", {31'd0, conv_busy}, 32'd1);
        @(negedge clk);
        check_output("busy drop", {31'd0, conv_busy}, 32'd0);
        push_field(201, 0, {8'h9F, 8'h25, 8'h0D, 8'h99});
        drain(20);

        hex_mode = 1'b1;
        repeat (3) @(negedge clk);
        check_output("hex no retrigger", {31'd0, conv_busy}, 32'd0);
        push_field(202, 0, {8'h9F, 8'h25, 8'h0D, 8'h99});
        drain(20);
        hex_mode = 1'b0;

        apply_stimulus(16'd100, 1'b0, 1'b0);
        apply_stimulus(16'd7, 1'b0, 1'b0);
        apply_stimulus(16'd42, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check_output("chain no gap", {31'd0, conv_busy}, 32'd1);
        push_field(300, 0, {8'h03, 8'h9F, 8'h03, 8'h03});
        drain(15);
        check_output("chain busy end", {31'd0, conv_busy}, 32'd1);
        @(negedge clk);
        check_output("chain done", {31'd0, conv_busy}, 32'd0);
        push_field(301, 0, {8'h03, 8'h03, 8'h99, 8'h25});
        drain(20);

        apply_stimulus(16'd1234, 1'b0, 1'b0);
        apply_stimulus(16'd55, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("mid rst busy", {31'd0, conv_busy}, 32'd0);
        check_output("mid rst led_en", {24'd0, led_en}, 32'hFE);
        check_output("mid rst led_cx", {24'd0, led_cx}, 32'h03);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_output("pend discarded", {31'd0, conv_busy}, 32'd0);
        push_field(400, 0, {8'h03, 8'h03, 8'h03, 8'h03});
        push_field(400, 4, {8'h03, 8'h03, 8'h03, 8'h03});
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_display_gen.md
Name: seg_scan_display_gen

Overview:
Parametrised multiplexed 7-segment driver for the calculator front panel. Upper digits show the keypad entry register. Lower digits show a result value, converted to decimal by an iterative binary-to-BCD engine, or shown raw in hex mode. Adds over the previous driver:
- width, digit count and scan rate parameters
- multi-cycle conversion with busy flag and a one-deep pending buffer
- leading-zero blanking
- overflow indication

Parameters:
DIGITS, 8, total digit count (2..8)
ENTRY_DIGITS, 4, digits at the top reserved for entry; RES_DIGITS = DIGITS-ENTRY_DIGITS (>=1)
VAL_W, 16, result value width (4..32)
SCAN_DIV, 20000, clk cycles per digit slot (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (rst=0 resets)
key_valid  in  1  one-cycle strobe: shift key_num into entry
key_num  in  4  keypad nibble
clear  in  1  one-cycle strobe: zero entry register
value  in  VAL_W  unsigned result to display
value_valid  in  1  one-cycle strobe: capture value
hex_mode  in  1  1 = result digits show raw hex nibbles, no conversion
blank_lz  in  1  1 = blank leading zeros in both fields
conv_busy  out  1  converter running
led_en  out  DIGITS  active-low one-hot digit enable
led_cx  out  8  active-low segments {a,b,c,d,e,f,g,dp}

Behaviour:
- Reset (rst=0, async):
  - led_en = all ones except bit0 = 0
  - entry, result and pending registers = 0; conv_busy = 0
  - led_cx = code for '0'
- Scan:
  - Free-running divider; on terminal count (every SCAN_DIV cycles) led_en <= {led_en[0], led_en[DIGITS-1:1]}.
  - Order is 0, DIGITS-1, DIGITS-2, ..., 1.
  - led_cx is combinational from the active slot; no stale-latch fallback, so an illegal led_en gives blank.
- Entry register, ENTRY_DIGITS nibbles:
  - key_valid shifts left; key_num enters the LS nibble; the MS nibble is discarded.
  - clear has priority over key_valid in the same cycle.
  - Slot i >= RES_DIGITS shows entry nibble i-RES_DIGITS.
- Result capture, when value_valid:
  - hex_mode=1: result nibbles <= value[4*RES_DIGITS-1:0] directly, next cycle. Overflow if any higher value bit is set.
  - hex_mode=0 and idle: start conversion; conv_busy=1 the next cycle.
  - hex_mode=0 and busy: store value in the pending register (latest wins, overwrites any earlier pending).
- Conversion (double-dabble):
  - Exactly VAL_W iterations, one per cycle: add 3 to each BCD nibble >= 5, then shift in the next MSB.
  - The BCD register carries enough digits for 2^VAL_W - 1.
  - On the last iteration the result register updates atomically and conv_busy drops. The display shows the old result until then; no partial values are visible.
  - If pending is valid at completion, the pending conversion starts the next cycle (conv_busy stays 1 without a gap) and pending clears.
- Overflow:
  - Any BCD digit at or above position RES_DIGITS nonzero, or any hex bit above 4*RES_DIGITS set, sets the ovf flag.
  - While ovf: result slot 0 shows 'E'; other result slots blank.
- Leading-zero blanking (blank_lz=1):
  - Within each field, slots above the highest nonzero nibble show blank (8'hFF).
  - The LS slot of each field always shows a digit.
  - dp is always 1 (off).
- Segment codes (bits a..g,dp): 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:19 A:11 b:C1 c:E5 d:85 E:61 F:71; blank FF.
- Reset mid-conversion aborts it; pending is discarded.
- A hex_mode change does not retrigger conversion; it takes effect at the next value_valid.

Decomposition:
- Package seg_pkg holds:
  - the 16 segment codes, SEG_BLANK and SEG_E constants
  - a function for BCD digit count from VAL_W
- One sub-module, bin2bcd_seq:
  - inputs: start, bin
  - outputs: busy, done, bcd
  - parametrised by VAL_W
- Top level holds the scan divider, entry register, pending buffer and digit mux.

Test Plan:
- Default params: reset, release → led_en=8'hFE, led_cx=8'h03; after SCAN_DIV cycles led_en=8'h7F, then 8'hBF after another SCAN_DIV.
- Keys 1,2,3,4,5 then clear with key_valid same cycle → entry 2345 before, 0000 after the clear (clear wins).
- value=1234, value_valid, hex_mode=0 → conv_busy high 16 cycles; result slots 3..0 show 1,2,3,4 (9F,25,0D,99); unchanged during busy.
- value=100 then value=7 and value=42 while busy → after first done: 0100; then 0042 with no busy gap; the 7 is never displayed.
- value=65535, RES_DIGITS=4 → slot0 = 61 ('E'), slots1..3 = FF; hex_mode=1, value=16'hBEEF → C1,61,61,71 with no busy.
- blank_lz=1, value=5 → slots3..1 FF, slot0 49; rst low mid-conversion → conv_busy=0, result 0, pending empty.
